// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - display timing presets, sync polarity constants and helpers
package vga_timing_pkg;

    // Level of a sync output while inside its sync pulse.
    localparam logic SYNC_POS = 1'b1;
    localparam logic SYNC_NEG = 1'b0;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock)
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam logic VGA640_HS_POL = SYNC_NEG;
    localparam logic VGA640_VS_POL = SYNC_NEG;

    // 800x600 @ 72 Hz (50 MHz pixel clock)
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;
    localparam logic SVGA800_HS_POL = SYNC_POS;
    localparam logic SVGA800_VS_POL = SYNC_POS;

    // 1024x768 @ 60 Hz (65 MHz pixel clock)
    localparam int XGA1024_H_ACTIVE = 1024;
    localparam int XGA1024_H_FP     = 24;
    localparam int XGA1024_H_SYNC   = 136;
    localparam int XGA1024_H_BP     = 160;
    localparam int XGA1024_V_ACTIVE = 768;
    localparam int XGA1024_V_FP     = 3;
    localparam int XGA1024_V_SYNC   = 6;
    localparam int XGA1024_V_BP     = 29;
    localparam logic XGA1024_HS_POL = SYNC_NEG;
    localparam logic XGA1024_VS_POL = SYNC_NEG;

    // Length of a full line or frame from its four segments.
    function automatic int timing_total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - reset-valued shift register aligning late-stage sync signals
//  Ports: clk (in), rstn (async active-low, in), din[W] (in), dout[W] (out, din delayed DLY cycles).
//  DLY=0 is a straight pass-through; every stage resets to RST_VAL otherwise.
module sync_delay_line #(
    parameter int            W       = 4,
    parameter int            DLY     = 2,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DLY == 0) begin : g_pass
        // Clock and reset are irrelevant when there is nothing to store.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rstn};
        assign dout = din;
    end else begin : g_shift
        logic [W-1:0] stage [DLY];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < DLY; i++) begin
                    stage[i] <= RST_VAL;
                end
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DLY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DLY-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - parametrised display timing generator with early coordinates and late sync
//  Ports: pclk (in), rstn (async active-low, in), en (in, 0 holds timing at origin),
//         x/y (out, early counts), de_early/line_start/frame_start (out, early, aligned with x/y),
//         hen/ven/de/hs/vs (out, late stage: early values delayed PIPE_DLY cycles).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = SYNC_POS,
    parameter logic VS_POL   = SYNC_POS,
    parameter int   PIPE_DLY = 2,
    parameter int   X_W      = 11,
    parameter int   Y_W      = 10
) (
    input  logic           pclk,
    input  logic           rstn,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           de_early,
    output logic           line_start,
    output logic           frame_start,
    output logic           hen,
    output logic           ven,
    output logic           de,
    output logic           hs,
    output logic           vs
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Counter/compare widths; the fit checks below make these equal X_W/Y_W in any legal build.
    localparam int HCW = max_int(X_W, $clog2(H_TOTAL));
    localparam int VCW = max_int(Y_W, $clog2(V_TOTAL));

    localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_END    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_START = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SYNC_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_END    = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_START = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SYNC_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2**X_W) begin : g_err_x_w
        $error("vga_sync_gen: H_TOTAL does not fit in X_W bits");
    end
    if (V_TOTAL > 2**Y_W) begin : g_err_y_w
        $error("vga_sync_gen: V_TOTAL does not fit in Y_W bits");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
        $error("vga_sync_gen: porch and sync widths must be non-zero");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_err_dly
        $error("vga_sync_gen: PIPE_DLY must be in 0..15");
    end

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_wrap;
    logic           h_act, v_act, h_sync, v_sync;

    assign h_wrap = (h_cnt == H_LAST);
    assign h_act  = (h_cnt < H_ACT_END);
    assign v_act  = (v_cnt < V_ACT_END);
    assign h_sync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign v_sync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

    // Holding the counters at the origin while disabled is what guarantees that
    // re-enabling always starts a whole frame.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VCW'(1);
        end else begin
            h_cnt <= h_cnt + HCW'(1);
        end
    end

    // Early stage: one register rank fed by the current counts, so x/y and the
    // strobes always describe the same pixel.
    logic hen_e, ven_e, hs_e, vs_e;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            x           <= '0;
            y           <= '0;
            de_early    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hen_e       <= 1'b0;
            ven_e       <= 1'b0;
            hs_e        <= ~HS_POL;
            vs_e        <= ~VS_POL;
        end else if (!en) begin
            x           <= '0;
            y           <= '0;
            de_early    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hen_e       <= 1'b0;
            ven_e       <= 1'b0;
            hs_e        <= ~HS_POL;
            vs_e        <= ~VS_POL;
        end else begin
            x           <= h_cnt[X_W-1:0];
            y           <= v_cnt[Y_W-1:0];
            de_early    <= h_act && v_act;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            hen_e       <= h_act;
            ven_e       <= v_act;
            hs_e        <= h_sync ? HS_POL : ~HS_POL;
            vs_e        <= v_sync ? VS_POL : ~VS_POL;
        end
    end

    // de travels with hen/ven through the delay line; since de_early is hen_e&ven_e
    // of the same cycle, the delayed copy equals hen&ven of the delayed values while
    // staying a register output even when PIPE_DLY is 0.
    logic [4:0] late;

    sync_delay_line #(
        .W       (5),
        .DLY     (PIPE_DLY),
        .RST_VAL ({3'b000, ~HS_POL, ~VS_POL})
    ) u_late (
        .clk  (pclk),
        .rstn (rstn),
        .din  ({hen_e, ven_e, de_early, hs_e, vs_e}),
        .dout (late)
    );

    assign hen = late[4];
    assign ven = late[3];
    assign de  = late[2];
    assign hs  = late[1];
    assign vs  = late[0];

endmodule
